// File: rtl/freq_meas_pkg.sv
// Shared types and elaboration helpers for the frequency measurement path.
package freq_meas_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, DIV, DONE} state_t;

  localparam int unsigned DEFAULT_CLK_FREQ_HZ = 200_000_000;

  // The dividend is CLK_FREQ_HZ plus at most half the largest period, and it
  // must fit in the dividend/quotient width.
  function automatic bit widths_ok(input longint unsigned clk_hz,
                                   input int unsigned     period_w,
                                   input int unsigned     div_w);
    return (clk_hz + (64'd1 << (period_w - 1))) < (64'd1 << div_w);
  endfunction

endpackage

// File: rtl/seq_udiv.sv
// Generic unsigned radix-2 restoring divider: one quotient bit per cycle,
// MSB first. start loads the operands, abort drops an ongoing division, and
// last_step is high during the cycle whose edge produces the final bit.
module seq_udiv #(
  parameter int DIVIDEND_W = 28,
  parameter int DIVISOR_W  = 18
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic                  active,
  output logic                  last_step
);

  localparam int CNT_W = $clog2(DIVIDEND_W);

  logic [DIVIDEND_W-1:0] dividend_r;
  logic [DIVISOR_W-1:0]  divisor_r;
  logic [DIVISOR_W-1:0]  rem_r;
  logic [CNT_W-1:0]      bit_cnt;
  logic [DIVISOR_W:0]    trial;
  logic                  take;

  // Shift the next dividend bit into the partial remainder and compare.
  always_comb begin
    trial = {rem_r, dividend_r[bit_cnt]};
    take  = (trial >= {1'b0, divisor_r});
  end

  assign last_step = active && (bit_cnt == '0);

  // Operand load and one restoring step per cycle while active.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dividend_r <= '0;
      divisor_r  <= '0;
      rem_r      <= '0;
      bit_cnt    <= '0;
      quotient   <= '0;
      active     <= 1'b0;
    end else if (abort) begin
      active <= 1'b0;
    end else if (start) begin
      // NOTE: sequential state uses <= so every register here sees the
      // pre-edge values of the others, regardless of statement order.
      dividend_r <= dividend;
      divisor_r  <= divisor;
      rem_r      <= '0;
      bit_cnt    <= CNT_W'(DIVIDEND_W - 1);
      quotient   <= '0;
      active     <= 1'b1;
    end else if (active) begin
      // The remainder stays below the divisor, so it fits DIVISOR_W bits.
      rem_r    <= DIVISOR_W'(take ? (trial - {1'b0, divisor_r}) : trial);
      quotient <= {quotient[DIVIDEND_W-2:0], take};
      bit_cnt  <= bit_cnt - 1'b1;
      if (bit_cnt == '0) active <= 1'b0;
    end
  end

endmodule

// File: rtl/period_to_freq.sv
// Converts a stable period (in clk cycles) into a frequency in Hz using the
// sequential divider. Optional macro FREQ_ROUND_EN: adds period/2 to the
// dividend for round-to-nearest; undefined gives a truncated quotient.
module period_to_freq
  import freq_meas_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ  = DEFAULT_CLK_FREQ_HZ,
  parameter int          PERIOD_WIDTH = 18,
  parameter int          DIV_WIDTH    = 28
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [PERIOD_WIDTH-1:0] period,
  input  logic                    stable,
  output logic [DIV_WIDTH-1:0]    freq_hz,
  output logic                    freq_valid,
  output logic                    freq_locked,
  output logic                    busy
);

  if (!widths_ok(longint'(CLK_FREQ_HZ), PERIOD_WIDTH, DIV_WIDTH)) begin : g_width_check
    $error("period_to_freq: CLK_FREQ_HZ + 2^(PERIOD_WIDTH-1) must be below 2^DIV_WIDTH");
  end

  localparam logic [DIV_WIDTH-1:0] CLK_DIVIDEND = DIV_WIDTH'(CLK_FREQ_HZ);

  state_t                  state;
  logic [PERIOD_WIDTH-1:0] divisor_r;
  logic [PERIOD_WIDTH-1:0] last_period;
  logic [DIV_WIDTH-1:0]    dividend;
  logic [DIV_WIDTH-1:0]    div_quotient;
  logic                    div_active;
  logic                    div_last;
  logic                    div_start;
  logic                    div_abort;

`ifdef FREQ_ROUND_EN
  assign dividend = CLK_DIVIDEND + DIV_WIDTH'(divisor_r >> 1);
`else
  assign dividend = CLK_DIVIDEND;
`endif

  // Losing stable while loading or dividing throws the division away.
  assign div_start = (state == LOAD) && stable;
  assign div_abort = ((state == LOAD) || (state == DIV)) && !stable;

  seq_udiv #(
    .DIVIDEND_W (DIV_WIDTH),
    .DIVISOR_W  (PERIOD_WIDTH)
  ) u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start),
    .abort     (div_abort),
    .dividend  (dividend),
    .divisor   (divisor_r),
    .quotient  (div_quotient),
    .active    (div_active),
    .last_step (div_last)
  );

  // Control FSM: change detection, abort handling and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      divisor_r   <= '0;
      last_period <= '0;
      freq_hz     <= '0;
      freq_valid  <= 1'b0;
      freq_locked <= 1'b0;
      busy        <= 1'b0;
    end else begin
      freq_valid <= 1'b0;
      if (!stable) freq_locked <= 1'b0;
      case (state)
        IDLE: begin
          if (stable && (period != '0) && (period != last_period)) begin
            divisor_r   <= period;
            last_period <= period;
            state       <= LOAD;
          end
        end
        LOAD: begin
          if (!stable) begin
            last_period <= '0;
            busy        <= 1'b0;
            state       <= IDLE;
          end else begin
            busy  <= 1'b1;
            state <= DIV;
          end
        end
        DIV: begin
          if (!stable) begin
            last_period <= '0;
            busy        <= 1'b0;
            state       <= IDLE;
          end else if (div_last) begin
            state <= DONE;
          end
        end
        DONE: begin
          freq_hz     <= div_quotient;
          freq_valid  <= 1'b1;
          freq_locked <= stable;
          busy        <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The divider's own activity flag mirrors busy; it is not needed here.
  logic unused_ok;
  assign unused_ok = div_active;

endmodule
